// File: rtl/lut_mux_seq.sv
// lut_mux_seq: registered 2^SEL_W-entry truth-table mux with a serial shadow/active table reload.
// Rev 1.0. Optional macro LUT_ABORT_EN: cfg_start during a load restarts it.
`default_nettype none

module lut_mux_seq #(
  parameter int SEL_W = 3,
  parameter logic [(1<<SEL_W)-1:0] INIT = 8'b1001_0110
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_bit,
  output logic             cfg_done,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  output logic             Y
);

  localparam int DEPTH = 1 << SEL_W;
  localparam logic [SEL_W:0] LAST_IDX = (SEL_W+1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W:0]   cnt, cnt_nxt;
  logic [DEPTH-1:0] shadow, shadow_nxt, active;
  logic             abort, accept, last;

`ifdef LUT_ABORT_EN
  assign abort = (state == LOAD) && cfg_start;
`else
  assign abort = 1'b0;
`endif

  // A restart cycle discards its bit, so it can never be the committing one.
  assign accept    = (state == LOAD) && cfg_valid && !abort;
  assign last      = accept && (cnt == LAST_IDX);
  assign cfg_ready = (state == LOAD);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    if (accept) begin
      shadow_nxt[cnt[SEL_W-1:0]] = cfg_bit;
    end
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          cnt_nxt = '0;
        end else if (last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (accept) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= INIT;
      active   <= INIT;
      cfg_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shadow   <= shadow_nxt;
      cfg_done <= last;
      if (last) begin
        active <= shadow_nxt;
      end
    end
  end

  // Evaluation reads the pre-commit table on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Y <= active[in_sel];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/lut_mux_seq.md
# lut_mux_seq

Programmable, registered truth-table multiplexer. It generalises the fixed-constant 8:1 / 4:1 / 2:1 mux function implementations to a 2^SEL_W-entry lookup table. The table is reloaded at run time through a serial, handshaked configuration port and a shadow/active double buffer, so evaluation is never interrupted. It sits between the lab's switch/select inputs and output logic wherever a reconfigurable 1-bit Boolean function of SEL_W variables is needed.

## Interface
- SEL_W, 3, number of function inputs; table depth DEPTH = 2^SEL_W; legal range 1..6
- INIT, 8'b1001_0110, reset contents of the active table, width DEPTH; bit k = output for select value k (default is 3-input odd parity)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse; begins a table load
- cfg_valid  in  1  cfg_bit is valid this cycle
- cfg_ready  out  1  block accepts a config bit this cycle
- cfg_bit  in  1  serial table bit; entry 0 first
- cfg_done  out  1  one-cycle pulse; new table committed
- in_valid  in  1  evaluate in_sel this cycle
- in_sel  in  SEL_W  select / function input vector; bit 0 = A (LSB)
- out_valid  out  1  Y is valid
- Y  out  1  table[in_sel] registered

## Operation
- FSM states: IDLE, LOAD.
- IDLE:
  - cfg_ready=0.
  - cfg_start -> LOAD, bit counter cnt <= 0.
- LOAD:
  - cfg_ready=1.
  - Each cycle with cfg_valid&cfg_ready: shadow[cnt] <= cfg_bit, cnt <= cnt+1.
  - cnt is SEL_W+1 bits wide and counts 0..DEPTH-1.
  - Accepting the bit at cnt==DEPTH-1 commits the table: active <= shadow with the final bit merged in, state -> IDLE, cfg_done pulses.
  - cfg_valid while cfg_ready=0 is ignored. cfg_start in IDLE while cfg_valid=1 accepts no bit that cycle.
- Evaluation is independent of the FSM and runs in both states from the active table only:
  - in_valid=1: Y <= active[in_sel], out_valid <= 1.
  - in_valid=0: out_valid <= 0, Y holds.
- Shadow contents are don't-care outside LOAD. A partial load never affects active.
- Reset (asynchronous, any state, including mid-load):
  - state=IDLE, cnt=0, active=INIT, shadow=INIT.
  - Y=0, out_valid=0, cfg_ready=0, cfg_done=0.

## Timing
- Evaluation latency is 1 cycle: in_valid at edge t gives out_valid/Y from edge t onward, visible in cycle t+1. Throughput is one evaluation per cycle. There is no output backpressure.
- Load with continuous cfg_valid:
  - cfg_start sampled at edge t0.
  - cfg_ready high from t0+1.
  - Final bit accepted at edge t0+DEPTH.
  - cfg_done high for the single cycle after that edge; cfg_ready low in the same cycle.
- Commit boundary:
  - in_valid sampled on the same edge as the final cfg bit uses the old table.
  - The next edge uses the new table.
- cfg_valid gaps stall cnt with no timeout.

## Configuration
- LUT_ABORT_EN defined: cfg_start during LOAD restarts the load. cnt <= 0, and the bit presented that cycle is discarded even if cfg_valid=1. If that cycle would have been the final bit, no commit and no cfg_done.
- LUT_ABORT_EN undefined: cfg_start is ignored in LOAD, and the load always runs to DEPTH bits.

## Test plan
- Reset, SEL_W=3, INIT default: sweep in_sel 0..7 with in_valid=1 -> Y sequence 0,1,1,0,1,0,0,1 one cycle late; out_valid=0 until the first in_valid.
- Load bits 1,1,0,0,1,1,1,0 (entry 0 first) with continuous cfg_valid -> cfg_done pulses exactly 8 cycles after cfg_start is sampled. The following sweep 0..7 gives 1,1,0,0,1,1,1,0.
- Drive in_sel=3 every cycle during a load of all-ones -> Y=0 up to and including the final-bit edge, then Y=1 from the next edge on.
- Load with cfg_valid low on alternate cycles -> exactly 8 bits accepted, cfg_done after the 8th accepted bit, no extra bits consumed.
- Assert rst_n=0 after 4 of 8 bits -> all outputs 0 immediately; after release the table equals INIT, state is IDLE, cfg_ready=0.
- LUT_ABORT_EN: cfg_start after 5 bits, then 8 bits of 0xFF -> single cfg_done, table all ones. Without the macro, the same stimulus commits after the original 8th accepted bit.
